alu_arbiter: RTL and testbench

Shares one combinational ALU (the `alu_if` datapath: `ALUOP`, `porta`, `portb` → `out`, `negative`, `overflow`, `zero`) among up to four requesters, such as the per-core execute stages. The arbiter accepts one request at a time. It latches the winner's opcode and operands, drives the ALU for one cycle, registers the result and flags, and returns them to the winner with a one-cycle `done` pulse. It sits between the requesters and the single ALU instance.

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters (IDLE/ISSUE/RESP).
// Ports: CLK, RST (sync, active-high); req/req_op/req_a/req_b per requester;
//   done/gnt one-hot; res_out/res_neg/res_ovf/res_zero registered result;
//   busy; alu_op/alu_a/alu_b to the ALU; alu_out/alu_neg/alu_ovf/alu_zero back.
// Build option: define ALU_ARB_RR_EN for round-robin, else fixed priority.

package alu_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;
  localparam aluop_t ALU_ADD = 4'd0;
  localparam aluop_t ALU_SUB = 4'd1;
  localparam aluop_t ALU_AND = 4'd2;
  localparam aluop_t ALU_OR  = 4'd3;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  aluop_t [NREQ-1:0]    req_op,
  input  word_t [NREQ-1:0]     req_a,
  input  word_t [NREQ-1:0]     req_b,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      gnt,
  output word_t                res_out,
  output logic                 res_neg,
  output logic                 res_ovf,
  output logic                 res_zero,
  output logic                 busy,
  output aluop_t               alu_op,
  output word_t                alu_a,
  output word_t                alu_b,
  input  word_t                alu_out,
  input  logic                 alu_neg,
  input  logic                 alu_ovf,
  input  logic                 alu_zero
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] win;
  logic          any;
  aluop_t        op_q;
  word_t         a_q;
  word_t         b_q;

  assign any = |req;

`ifdef ALU_ARB_RR_EN
  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic          hit;

  // Search starts one past the last winner and wraps.
  always_comb begin
    win  = '0;
    cand = '0;
    hit  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!hit && req[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      ptr <= PW'(NREQ - 1);
    else if (state == IDLE && any)
      ptr <= win;
  end
`else
  // Descending scan so the lowest index wins.
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k])
        win = PW'(k);
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_out  <= '0;
      res_neg  <= 1'b0;
      res_ovf  <= 1'b0;
      res_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt  <= NREQ'(1) << win;
            op_q <= req_op[win];
            a_q  <= req_a[win];
            b_q  <= req_b[win];
          end
        end
        ISSUE: begin
          res_out  <= alu_out;
          res_neg  <= alu_neg;
          res_ovf  <= alu_ovf;
          res_zero <= alu_zero;
        end
        RESP:    gnt <= '0;
        default: gnt <= '0;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    done   = (state == RESP) ? gnt : '0;
    alu_op = op_q;
    alu_a  = a_q;
    alu_b  = b_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=4) with a behavioural ALU model.
// Expectations follow ALU_ARB_RR_EN when it is defined.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   req;
  aluop_t [3:0] req_op;
  word_t [3:0]  req_a;
  word_t [3:0]  req_b;
  logic [3:0]   done;
  logic [3:0]   gnt;
  word_t        res_out;
  logic         res_neg;
  logic         res_ovf;
  logic         res_zero;
  logic         busy;
  aluop_t       alu_op;
  word_t        alu_a;
  word_t        alu_b;
  word_t        alu_out;
  logic         alu_neg;
  logic         alu_ovf;
  logic         alu_zero;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.NREQ(4)) u_dut (
    .CLK(CLK), .RST(RST),
    .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .done(done), .gnt(gnt),
    .res_out(res_out), .res_neg(res_neg),
    .res_ovf(res_ovf), .res_zero(res_zero),
    .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_neg(alu_neg),
    .alu_ovf(alu_ovf), .alu_zero(alu_zero)
  );

  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_out = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_out = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      default: alu_out = '0;
    endcase
    alu_neg  = alu_out[31];
    alu_zero = (alu_out == '0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    step();
    step();
    n_chk++;
    if ({busy, gnt, done} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got busy/gnt/done=%b expected 0", {busy, gnt, done});
    end
    n_chk++;
    if ({res_out, res_neg, res_ovf, res_zero, alu_op, alu_a, alu_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got res=%h op=%h a=%h b=%h expected all 0",
               res_out, alu_op, alu_a, alu_b);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_single();
    req = 4'b0001;
    req_op[0] = ALU_ADD;
    req_a[0] = 32'd5;
    req_b[0] = 32'd7;
    step();
    n_chk++;
    if ({busy, gnt, done} !== {1'b1, 4'b0001, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_issue: got busy/gnt/done=%b expected 1_0001_0000", {busy, gnt, done});
    end
    step();
    n_chk++;
    if ({busy, done, res_out, res_zero} !== {1'b1, 4'b0001, 32'd12, 1'b0}) begin
      n_fail++;
      $display("FAIL single_resp: got busy=%b done=%b res=%0d z=%b expected 1 0001 12 0",
               busy, done, res_out, res_zero);
    end
    req = '0;
    step();
    n_chk++;
    if ({busy, gnt, done} !== 9'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy/gnt/done=%b expected 0", {busy, gnt, done});
    end
  endtask

  task automatic test_simultaneous();
    req_op[0] = ALU_SUB;
    req_a[0] = 32'd3;
    req_b[0] = 32'd3;
    req_op[1] = ALU_ADD;
    req_a[1] = 32'd10;
    req_b[1] = 32'd20;
    req = 4'b0011;
    step();
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL sim_gnt0: got %b expected 0001", gnt);
    end
    step();
    n_chk++;
    if ({done, res_out, res_zero} !== {4'b0001, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sim_done0: got done=%b res=%0d z=%b expected 0001 0 1",
               done, res_out, res_zero);
    end
`ifdef ALU_ARB_RR_EN
    req[0] = 1'b0;
    step();
    step();
    n_chk++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL sim_gnt1: got %b expected 0010", gnt);
    end
    step();
    n_chk++;
    if ({done, res_out} !== {4'b0010, 32'd30}) begin
      n_fail++;
      $display("FAIL sim_done1: got done=%b res=%0d expected 0010 30", done, res_out);
    end
`else
    step();
    step();
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL sim_starve: got %b expected 0001", gnt);
    end
    step();
    n_chk++;
    if ({done, res_zero} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL sim_repeat: got done=%b z=%b expected 0001 1", done, res_zero);
    end
`endif
    req = '0;
    step();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
`ifdef ALU_ARB_RR_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_op[i] = ALU_OR;
      req_a[i] = 32'h100 << i;
      req_b[i] = 32'd0;
    end
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      step();
      n_chk++;
      if (gnt !== exp_g[r]) begin
        n_fail++;
        $display("FAIL fair_gnt%0d: got %b expected %b", r, gnt, exp_g[r]);
      end
      step();
      if (r == 4) req = '0;
      step();
    end
  endtask

  task automatic test_overflow();
    req_op[0] = ALU_ADD;
    req_a[0] = 32'h7FFF_FFFF;
    req_b[0] = 32'd1;
    req = 4'b0001;
    step();
    step();
    n_chk++;
    if ({done, res_out, res_ovf, res_neg, res_zero} !==
        {4'b0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf: got done=%b res=%h v=%b n=%b z=%b expected 0001 80000000 1 1 0",
               done, res_out, res_ovf, res_neg, res_zero);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid_op();
    logic saw_done;
    req_op[0] = ALU_ADD;
    req_a[0] = 32'd5;
    req_b[0] = 32'd7;
    req_op[1] = ALU_ADD;
    req_a[1] = 32'd1;
    req_b[1] = 32'd1;
    req = 4'b0001;
    step();
    RST = 1'b1;
    saw_done = 1'b0;
    step();
    n_chk++;
    if ({busy, gnt, done, res_out, alu_a} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst: got busy=%b gnt=%b done=%b res=%h a=%h expected 0",
               busy, gnt, done, res_out, alu_a);
    end
    RST = 1'b0;
    req = 4'b0011;
    step();
    if (done !== 4'b0) saw_done = 1'b1;
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_rst_regrant: got %b expected 0001", gnt);
    end
    step();
    n_chk++;
    if ({saw_done, done, res_out} !== {1'b0, 4'b0001, 32'd12}) begin
      n_fail++;
      $display("FAIL mid_rst_done: got early=%b done=%b res=%0d expected 0 0001 12",
               saw_done, done, res_out);
    end
    req = '0;
    step();
  endtask

  task automatic test_operand_change();
    RST = 1'b1;
    step();
    RST = 1'b0;
    req_op[0] = ALU_ADD;
    req_a[0] = 32'd5;
    req_b[0] = 32'd7;
    req = 4'b0001;
    step();
    req_a[0] = 32'd9;
    step();
    n_chk++;
    if ({done, res_out} !== {4'b0001, 32'd12}) begin
      n_fail++;
      $display("FAIL op_latch: got done=%b res=%0d expected 0001 12", done, res_out);
    end
    req = '0;
    step();
    n_chk++;
    if ({busy, alu_a} !== {1'b0, 32'd5}) begin
      n_fail++;
      $display("FAIL op_hold: got busy=%b alu_a=%0d expected 0 5", busy, alu_a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overflow();
    test_reset_mid_op();
    test_operand_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
